// File: rtl/scie_pkg.sv
// Shared definitions for the SCIE complex FIR unit: opcodes, complex type, default sizes.
package scie_pkg;

  localparam int unsigned DEF_NTAPS  = 5;
  localparam int unsigned DEF_DATA_W = 16;

  localparam logic [6:0] OP_LOADC = 7'h0B;
  localparam logic [6:0] OP_PUSH  = 7'h2B;
  localparam logic [6:0] OP_FIR   = 7'h5B;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } complex_t;

endpackage

// File: rtl/scie_cmul.sv
// Combinational full-precision complex multiplier: (ar + j*ai) * (br + j*bi).
module scie_cmul #(
  parameter int unsigned DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   ar,
  input  logic signed [DATA_W-1:0]   ai,
  input  logic signed [DATA_W-1:0]   br,
  input  logic signed [DATA_W-1:0]   bi,
  output logic signed [2*DATA_W:0]   p_re,
  output logic signed [2*DATA_W:0]   p_im
);

  localparam int unsigned PW = 2 * DATA_W + 1;

  logic signed [PW-1:0] rr, ii, ri, ir;

  // Operands widened first so every product and the final add/sub are exact.
  assign rr   = PW'(ar) * PW'(br);
  assign ii   = PW'(ai) * PW'(bi);
  assign ri   = PW'(ar) * PW'(bi);
  assign ir   = PW'(ai) * PW'(br);
  assign p_re = rr - ii;
  assign p_im = ri + ir;

endmodule

// File: rtl/scie_pipelined.sv
// SCIE custom-instruction unit: NTAPS-tap complex FIR with LOADC / PUSH / FIR opcodes.
// Define SCIE_SATURATE_EN to saturate the result instead of wrapping it.
module scie_pipelined
  import scie_pkg::*;
#(
  parameter int unsigned NTAPS  = DEF_NTAPS,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_valid,
  input  logic [31:0]              io_insn,
  input  logic signed [DATA_W-1:0] io_rs1_real,
  input  logic signed [DATA_W-1:0] io_rs1_imag,
  input  logic [31:0]              io_rs2,
  output logic signed [DATA_W-1:0] io_rd_real,
  output logic signed [DATA_W-1:0] io_rd_imag
);

  localparam int unsigned PW    = 2 * DATA_W + 1;
  localparam int unsigned ACC_W = PW + $clog2(NTAPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  complex_t c_q [NTAPS];
  complex_t x_q [NTAPS];
  complex_t rd_q;
  complex_t rd_d;
  complex_t rs1;

  logic signed [PW-1:0]    prod_re [NTAPS];
  logic signed [PW-1:0]    prod_im [NTAPS];
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic [6:0]              opcode;

  assign opcode = io_insn[6:0];
  assign rs1    = '{re: io_rs1_real, im: io_rs1_imag};

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    scie_cmul #(.DATA_W(DATA_W)) u_cmul (
      .ar   (c_q[k].re),
      .ai   (c_q[k].im),
      .br   (x_q[k].re),
      .bi   (x_q[k].im),
      .p_re (prod_re[k]),
      .p_im (prod_im[k])
    );
  end

  always_comb begin
    acc_re = '0;
    acc_im = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_re = acc_re + ACC_W'(prod_re[k]);
      acc_im = acc_im + ACC_W'(prod_im[k]);
    end
  end

  always_comb begin
    rd_d.re = acc_re[DATA_W-1:0];
    rd_d.im = acc_im[DATA_W-1:0];
`ifdef SCIE_SATURATE_EN
    if (acc_re > SAT_MAX)      rd_d.re = SAT_MAX[DATA_W-1:0];
    else if (acc_re < SAT_MIN) rd_d.re = SAT_MIN[DATA_W-1:0];
    if (acc_im > SAT_MAX)      rd_d.im = SAT_MAX[DATA_W-1:0];
    else if (acc_im < SAT_MIN) rd_d.im = SAT_MIN[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_q <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        c_q[k] <= '0;
        x_q[k] <= '0;
      end
    end else if (io_valid) begin
      case (opcode)
        OP_LOADC: begin
          // Indices at or beyond NTAPS match no tap, so the write is dropped.
          for (int k = 0; k < NTAPS; k++) begin
            if (io_rs2[2:0] == 3'(k)) c_q[k] <= rs1;
          end
        end
        OP_PUSH: begin
          for (int k = NTAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
          x_q[0] <= rs1;
        end
        OP_FIR:  rd_q <= rd_d;
        default: ;
      endcase
    end
  end

  assign io_rd_real = rd_q.re;
  assign io_rd_imag = rd_q.im;

endmodule

// File: tb/tb_scie_pipelined.sv
// Directed self-checking bench for scie_pipelined using hand-computed FIR results.
module tb_scie_pipelined;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               io_valid = 1'b0;
  logic [31:0]        io_insn = '0;
  logic signed [15:0] io_rs1_real = '0;
  logic signed [15:0] io_rs1_imag = '0;
  logic [31:0]        io_rs2 = '0;
  logic signed [15:0] io_rd_real;
  logic signed [15:0] io_rd_imag;

  int checks = 0;
  int errors = 0;

  scie_pipelined dut (
    .clock       (clock),
    .reset       (reset),
    .io_valid    (io_valid),
    .io_insn     (io_insn),
    .io_rs1_real (io_rs1_real),
    .io_rs1_imag (io_rs1_imag),
    .io_rs2      (io_rs2),
    .io_rd_real  (io_rd_real),
    .io_rd_imag  (io_rd_imag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_rd(input string tag, input int re, input int im);
    check({tag, ".re"}, int'(io_rd_real), re);
    check({tag, ".im"}, int'(io_rd_imag), im);
  endtask

  // Issue one instruction for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic issue(input logic valid, input logic [6:0] op, input int re, input int im,
                       input int rs2);
    @(negedge clock);
    io_valid    = valid;
    io_insn     = {25'h0, op};
    io_rs1_real = 16'(re);
    io_rs1_imag = 16'(im);
    io_rs2      = 32'(rs2);
    @(posedge clock);
    #1;
    io_valid = 1'b0;
  endtask

  task automatic loadc(input int idx, input int re, input int im);
    issue(1'b1, 7'h0B, re, im, idx);
  endtask

  task automatic push(input int re, input int im);
    issue(1'b1, 7'h2B, re, im, 0);
  endtask

  task automatic fir();
    issue(1'b1, 7'h5B, 0, 0, 0);
  endtask

  task automatic idle();
    issue(1'b0, 7'h2B, 99, 99, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_rd("reset", 0, 0);
    @(negedge clock);
    reset = 1'b1;

    loadc(0, -12, -9);
    loadc(1, -27, -35);
    loadc(2, -5, -12);
    loadc(3, 28, 11);
    loadc(4, -9, 16);
    push(25, 46);
    check_rd("push_keeps_rd", 0, 0);
    fir();
    check_rd("fir1", 114, -777);
    idle();
    check_rd("fir1_hold", 114, -777);

    push(-34, 43);
    idle();
    fir();
    check_rd("fir2_idle", 1730, -2327);

    push(48, 29);
    fir();
    check_rd("fir3", 2535, -1281);
    push(-16, -25);
    fir();
    check_rd("fir4", 566, -263);
    push(11, -14);
    fir();
    check_rd("fir5", -2979, 1399);
    push(-13, 37);
    fir();
    check_rd("fir6_drop", 125, 392);

    // Unknown opcode with valid high must not touch any state.
    issue(1'b1, 7'h33, 7, 7, 1);
    check_rd("bad_op_rd", 125, 392);
    loadc(7, 5, 5);
    check_rd("loadc_oor_rd", 125, 392);
    fir();
    check_rd("loadc_oor_fir", 125, 392);

    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_rd("mid_reset", 0, 0);
    @(negedge clock);
    reset = 1'b1;
    fir();
    check_rd("reset_fir", 0, 0);

    // x[1] must be cleared: a unit coefficient on tap 1 still yields zero.
    loadc(1, 1, 0);
    fir();
    check_rd("x_cleared", 0, 0);

    loadc(0, 200, 0);
    push(200, 0);
    fir();
`ifdef SCIE_SATURATE_EN
    check_rd("overflow", 32767, 0);
`else
    check_rd("overflow", -25536, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/scie_pipelined.md
# scie_pipelined

Custom-instruction execution unit for the core's SCIE slot. It implements a 5-tap complex-valued FIR filter. Complex coefficients are loaded by one instruction, complex samples are pushed into a delay line by a second, and a third instruction returns the filtered output one cycle later on `rd`. It sits beside the integer pipeline and takes operands already read from the register file.

## Interface
- `NTAPS`, default 5: number of taps (coefficient registers and delay-line depth).
- `DATA_W`, default 16: width of each real/imag component.
- `clock` input 1: single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-low. 0 means in reset, sampled on `clock`.
- `io_valid` input 1: instruction present this cycle. No state changes when 0.
- `io_insn` input 32: instruction word. Only `io_insn[6:0]` (opcode) is decoded.
- `io_rs1_real` input 16 signed: real part of the complex operand.
- `io_rs1_imag` input 16 signed: imaginary part of the complex operand.
- `io_rs2` input 32: tap index for coefficient load. Bits [2:0] are used.
- `io_rd_real` output 16 signed: real part of the FIR result, registered.
- `io_rd_imag` output 16 signed: imaginary part of the FIR result, registered.

## Operation
- State:
  - Coefficient file `c[0..NTAPS-1]`, complex.
  - Delay line `x[0..NTAPS-1]`, complex; `x[0]` is the newest sample.
  - Output register `rd`.
- Opcode 0x0B (LOADC), when valid: `c[rs2[2:0]] <= rs1`.
  - If the index is ≥ NTAPS, the write is ignored.
- Opcode 0x2B (PUSH), when valid: `x[k] <= x[k-1]` for k = NTAPS-1 down to 1, and `x[0] <= rs1`.
  - The oldest sample is discarded.
- Opcode 0x5B (FIR), when valid: `rd <= Σ c[k]·x[k]` over k = 0..NTAPS-1, using complex multiply.
  - Real part: `ar·br − ai·bi`. Imaginary part: `ar·bi + ai·br`.
- Any other opcode, or `io_valid`=0: no state change.
- `rd` holds its value except on FIR.
- LOADC and PUSH never alter `rd`.
- Arithmetic:
  - Each 16×16 product is a full 32-bit signed value.
  - The per-tap complex component is 33 bits.
  - The accumulator is at least 36 bits signed, exact.
  - The result is the low 16 bits of the accumulator (two's-complement wrap), unless the saturation option below is enabled.
- FIR reads the delay line and coefficients as they were before the clock edge. One instruction per cycle, so no simultaneous operations exist.

## Timing
- Reset (`reset`=0 at a rising edge):
  - All `c`, all `x` and `rd` become 0.
  - Outputs read 0 from the cycle after reset.
- Reset mid-sequence discards all coefficients and samples; no partial state survives.
- FIR latency is 1 cycle. An instruction issued in cycle N shows its result on `io_rd_*` after edge N, and the value is stable through cycle N+1 and beyond.
- LOADC and PUSH take effect at the edge; a FIR in the next cycle sees the new values.
- There is no handshake or backpressure. Every valid instruction is accepted in one cycle.

## Configuration
- `SCIE_SATURATE_EN` defined: the 16-bit result is saturated to [−32768, 32767], separately for real and imag.
- `SCIE_SATURATE_EN` undefined: the result wraps, keeping the low 16 bits.

## Structure
- Package `scie_pkg` holds:
  - opcode constants `OP_LOADC`=7'h0B, `OP_PUSH`=7'h2B, `OP_FIR`=7'h5B;
  - a packed `complex_t` typedef {real, imag}, signed 16 bits each;
  - `NTAPS` and `DATA_W` defaults.
- Sub-module `scie_cmul`: combinational complex multiplier returning full-precision 33-bit real/imag. Instantiate it NTAPS times.

## Test plan
- After reset, load coefficients with opcode 0x0B: c0=(−12,−9), c1=(−27,−35), c2=(−5,−12), c3=(28,11), c4=(−9,16) via rs2=0..4. Push (25,46), then FIR. Required: rd=(114,−777).
- Continue with push (−34,43), idle cycle with `io_valid`=0, then FIR. Required: rd=(1730,−2327). The idle cycle must not push again.
- Continue pushes (48,29), (−16,−25), (11,−14), with a FIR after each. Required: rd=(2535,−1281), (566,−263), (−2979,1399).
- With the window full, push (−13,37) then FIR. Required: rd=(125,392), showing the oldest sample dropped.
- Issue LOADC with rs2=7 (out of range) and rs1=(5,5), then FIR. Required: rd unchanged and the coefficients unchanged.
- Assert reset mid-sequence, then FIR. Required: rd=(0,0) and all taps cleared.
- Overflow check: c0=(200,0), push (200,0), FIR.
  - Without `SCIE_SATURATE_EN`: rd.real=−25536.
  - With `SCIE_SATURATE_EN`: rd.real=32767.
